// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer: FSM states,
// register function codes, and instruction field slice positions.
package fetch_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH_LO = 3'd1,
      FETCH_HI = 3'd2,
      DECODE   = 3'd3,
      EXEC     = 3'd4,
      HALT     = 3'd5
   } state_e;

   localparam logic [1:0] FS_DEC  = 2'b00;
   localparam logic [1:0] FS_INC  = 2'b01;
   localparam logic [1:0] FS_LOAD = 2'b10;
   localparam logic [1:0] FS_CLR  = 2'b11;

   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 12;
   localparam int MODE_MSB = 11;
   localparam int MODE_LSB = 10;
   localparam int REG_MSB  = 9;
   localparam int REG_LSB  = 8;
   localparam int ADDR_MSB = 7;
   localparam int ADDR_LSB = 0;

   localparam logic MEM_CS_ACTIVE = 1'b0;

endpackage

// File: rtl/instr_decoder.sv
// Registered split of the fetched instruction into fields; the valid flag is
// raised by the load and dropped when the execute stage retires the instruction.
module instr_decoder
   import fetch_pkg::*;
#(
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               retire_i,
   input  logic [INSTR_W-1:0] ir_i,
   output logic               dec_valid_o,
   output logic [3:0]         opcode_o,
   output logic [1:0]         mode_o,
   output logic [1:0]         reg_o,
   output logic [7:0]         addr_o
);

   logic       vld_q,    vld_d;
   logic [3:0] opcode_q, opcode_d;
   logic [1:0] mode_q,   mode_d;
   logic [1:0] reg_q,    reg_d;
   logic [7:0] addr_q,   addr_d;

   always_comb begin
      vld_d    = vld_q;
      opcode_d = opcode_q;
      mode_d   = mode_q;
      reg_d    = reg_q;
      addr_d   = addr_q;
      if (load_i) begin
         vld_d    = 1'b1;
         opcode_d = ir_i[OPC_MSB:OPC_LSB];
         mode_d   = ir_i[MODE_MSB:MODE_LSB];
         reg_d    = ir_i[REG_MSB:REG_LSB];
         addr_d   = ir_i[ADDR_MSB:ADDR_LSB];
      end else if (retire_i) begin
         vld_d = 1'b0;
      end
   end

   // Fields are cleared on reset too, so a reset leaves no stale instruction visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q    <= 1'b0;
         opcode_q <= '0;
         mode_q   <= '0;
         reg_q    <= '0;
         addr_q   <= '0;
      end else begin
         vld_q    <= vld_d;
         opcode_q <= opcode_d;
         mode_q   <= mode_d;
         reg_q    <= reg_d;
         addr_q   <= addr_d;
      end
   end

   assign dec_valid_o = vld_q;
   assign opcode_o    = opcode_q;
   assign mode_o      = mode_q;
   assign reg_o       = reg_q;
   assign addr_o      = addr_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch controller driving ALU_System memory/IR/ARF controls.
// Optional macro FETCH_STATS_EN adds the retired-instruction counter instr_count.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [1:0] PC_OUTSEL = 2'b00,
   parameter logic [3:0] PC_RSEL   = 4'b1000,
   parameter int         INSTR_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               halt_req,
   input  logic               exec_done,
   input  logic [INSTR_W-1:0] ir_in,
   output logic               bus_own,
   output logic               mem_cs,
   output logic               mem_wr,
   output logic               ir_enable,
   output logic               ir_lh,
   output logic [1:0]         ir_funsel,
   output logic [1:0]         arf_outdsel,
   output logic [1:0]         arf_funsel,
   output logic [3:0]         arf_regsel,
   output logic               dec_valid,
   output logic [3:0]         dec_opcode,
   output logic [1:0]         dec_mode,
   output logic [1:0]         dec_reg,
   output logic [7:0]         dec_addr,
   output logic               halted,
`ifdef FETCH_STATS_EN
   output logic [15:0]        instr_count,
`endif
   output logic [2:0]         seq_t
);

   state_e     state_q, state_d;
   logic [2:0] seq_q,   seq_d;
   logic       retire;

   assign retire = (state_q == EXEC) && exec_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         seq_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         seq_q   <= seq_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (run) state_d = FETCH_LO;
         FETCH_LO: state_d = FETCH_HI;
         FETCH_HI: state_d = DECODE;
         DECODE:   state_d = EXEC;
         EXEC:     if (exec_done) state_d = halt_req ? HALT : FETCH_LO;
         HALT:     if (run) state_d = FETCH_LO;
         default:  state_d = IDLE;
      endcase
   end

   // T restarts at every fetch and parks at 7 during a long execute.
   always_comb begin
      if (state_d == FETCH_LO || state_d == IDLE || state_d == HALT)
         seq_d = 3'd0;
      else if (seq_q == 3'd7)
         seq_d = 3'd7;
      else
         seq_d = seq_q + 3'd1;
   end

   always_comb begin
      bus_own     = 1'b0;
      mem_cs      = ~MEM_CS_ACTIVE;
      mem_wr      = 1'b0;
      ir_enable   = 1'b0;
      ir_lh       = 1'b0;
      ir_funsel   = FS_LOAD;
      arf_outdsel = PC_OUTSEL;
      arf_funsel  = FS_LOAD;
      arf_regsel  = 4'b0000;
      if (state_q == FETCH_LO || state_q == FETCH_HI) begin
         bus_own    = 1'b1;
         mem_cs     = MEM_CS_ACTIVE;
         ir_enable  = 1'b1;
         ir_lh      = (state_q == FETCH_HI);
         arf_regsel = PC_RSEL;
         arf_funsel = FS_INC;
      end
   end

   assign halted = (state_q == HALT);
   assign seq_t  = seq_q;

   instr_decoder #(.INSTR_W(INSTR_W)) u_dec (
      .clk         (clk),
      .rst         (rst),
      .load_i      (state_q == DECODE),
      .retire_i    (retire),
      .ir_i        (ir_in),
      .dec_valid_o (dec_valid),
      .opcode_o    (dec_opcode),
      .mode_o      (dec_mode),
      .reg_o       (dec_reg),
      .addr_o      (dec_addr)
   );

`ifdef FETCH_STATS_EN
   logic [15:0] count_q;

   always_ff @(posedge clk) begin
      if (rst)         count_q <= 16'd0;
      else if (retire) count_q <= count_q + 16'd1;
   end

   assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a tiny memory/IR/PC plant model.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst, run, halt_req, exec_done;
   logic [15:0] ir_in;
   logic        bus_own, mem_cs, mem_wr, ir_enable, ir_lh, dec_valid, halted;
   logic [1:0]  ir_funsel, arf_outdsel, arf_funsel, dec_mode, dec_reg;
   logic [3:0]  arf_regsel, dec_opcode;
   logic [7:0]  dec_addr;
   logic [2:0]  seq_t;
`ifdef FETCH_STATS_EN
   logic [15:0] instr_count;
`endif

   int checks   = 0;
   int failures = 0;

   logic [7:0]  mem [0:15];
   logic [7:0]  pc_q = 8'd0;
   logic [15:0] ir_q = 16'd0;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .exec_done(exec_done),
      .ir_in(ir_in), .bus_own(bus_own), .mem_cs(mem_cs), .mem_wr(mem_wr),
      .ir_enable(ir_enable), .ir_lh(ir_lh), .ir_funsel(ir_funsel),
      .arf_outdsel(arf_outdsel), .arf_funsel(arf_funsel), .arf_regsel(arf_regsel),
      .dec_valid(dec_valid), .dec_opcode(dec_opcode), .dec_mode(dec_mode),
      .dec_reg(dec_reg), .dec_addr(dec_addr), .halted(halted),
`ifdef FETCH_STATS_EN
      .instr_count(instr_count),
`endif
      .seq_t(seq_t)
   );

   // Plant: memory read at PC into the selected IR byte, PC increments on INC.
   always @(posedge clk) begin
      if (mem_cs == 1'b0 && mem_wr == 1'b0 && ir_enable && arf_outdsel == 2'b00) begin
         if (ir_lh) ir_q[15:8] <= mem[pc_q[3:0]];
         else       ir_q[7:0]  <= mem[pc_q[3:0]];
      end
      if (arf_regsel[3] && arf_funsel == 2'b01) pc_q <= pc_q + 8'd1;
   end
   assign ir_in = ir_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[0] = 8'h34; mem[1] = 8'h12;
      mem[2] = 8'hAB; mem[3] = 8'hC7;
      mem[4] = 8'h00; mem[5] = 8'hF0;
      mem[6] = 8'h5A; mem[7] = 8'h9E;
      rst = 1'b1; run = 1'b0; halt_req = 1'b0; exec_done = 1'b0;
      tick(); tick();
      rst = 1'b0;

      check("rst_bus_own", bus_own, 0);
      check("rst_mem_cs", mem_cs, 1);
      check("rst_ir_en", ir_enable, 0);
      check("rst_regsel", arf_regsel, 4'b0000);
      check("rst_funsel", arf_funsel, 2'b10);
      check("rst_valid", dec_valid, 0);
      check("rst_halted", halted, 0);
      check("rst_seq_t", seq_t, 0);
      check("rst_addr", dec_addr, 0);

      // Instruction 1 at PC=0
      run = 1'b1; tick(); run = 1'b0;
      check("flo_bus_own", bus_own, 1);
      check("flo_mem_cs", mem_cs, 0);
      check("flo_mem_wr", mem_wr, 0);
      check("flo_ir_lh", ir_lh, 0);
      check("flo_ir_funsel", ir_funsel, 2'b10);
      check("flo_regsel", arf_regsel, 4'b1000);
      check("flo_funsel", arf_funsel, 2'b01);
      check("flo_seq_t", seq_t, 0);
      tick();
      check("fhi_ir_lh", ir_lh, 1);
      check("fhi_seq_t", seq_t, 1);
      tick();
      check("dec_valid_low", dec_valid, 0);
      check("dec_bus_own", bus_own, 0);
      check("dec_pc", pc_q, 2);
      tick();
      check("i1_valid", dec_valid, 1);
      check("i1_opcode", dec_opcode, 4'h1);
      check("i1_mode", dec_mode, 2'd0);
      check("i1_reg", dec_reg, 2'd2);
      check("i1_addr", dec_addr, 8'h34);
      check("i1_seq_t", seq_t, 3);

      // Long execute: T saturates, fields hold, stray run ignored
      run = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      run = 1'b0;
      check("wait_valid", dec_valid, 1);
      check("wait_seq_t", seq_t, 7);
      check("wait_addr", dec_addr, 8'h34);
      check("wait_bus_own", bus_own, 0);

      exec_done = 1'b1; tick(); exec_done = 1'b0;
      check("loop_mem_cs", mem_cs, 0);
      check("loop_ir_lh", ir_lh, 0);
      check("loop_seq_t", seq_t, 0);
      check("loop_valid", dec_valid, 0);
      check("loop_hold_addr", dec_addr, 8'h34);

      // Instruction 2 at PC=2, retired in its first EXEC cycle with halt
      tick(); tick(); tick();
      check("i2_valid", dec_valid, 1);
      check("i2_opcode", dec_opcode, 4'hC);
      check("i2_mode", dec_mode, 2'd1);
      check("i2_reg", dec_reg, 2'd3);
      check("i2_addr", dec_addr, 8'hAB);
      exec_done = 1'b1; halt_req = 1'b1; tick(); exec_done = 1'b0; halt_req = 1'b0;
      check("halt_halted", halted, 1);
      check("halt_bus_own", bus_own, 0);
      check("halt_mem_cs", mem_cs, 1);
      check("halt_valid", dec_valid, 0);
      check("halt_seq_t", seq_t, 0);
      exec_done = 1'b1; tick(); exec_done = 1'b0;
      check("halt_ignore_done", halted, 1);
      check("halt_pc", pc_q, 4);

      // Resume, then reset in FETCH_HI
      run = 1'b1; tick(); run = 1'b0;
      check("resume_halted", halted, 0);
      check("resume_mem_cs", mem_cs, 0);
      tick();
      check("resume_ir_lh", ir_lh, 1);
      rst = 1'b1; run = 1'b1; exec_done = 1'b1; tick();
      check("midrst_mem_cs", mem_cs, 1);
      check("midrst_ir_en", ir_enable, 0);
      check("midrst_valid", dec_valid, 0);
      check("midrst_addr", dec_addr, 0);
      check("midrst_seq_t", seq_t, 0);
      rst = 1'b0; run = 1'b0; exec_done = 1'b0;
      tick();
      check("idle_stays", bus_own, 0);
      check("idle_pc", pc_q, 6);

      // Refetch from PC=6
      run = 1'b1; tick(); run = 1'b0;
      check("refetch_bus_own", bus_own, 1);
      tick(); tick(); tick();
      check("i3_valid", dec_valid, 1);
      check("i3_opcode", dec_opcode, 4'h9);
      check("i3_mode", dec_mode, 2'd3);
      check("i3_reg", dec_reg, 2'd2);
      check("i3_addr", dec_addr, 8'h5A);
      check("i3_pc", pc_q, 8);
      exec_done = 1'b1; tick(); exec_done = 1'b0;
      check("i3_loop_seq_t", seq_t, 0);
      check("i3_loop_bus_own", bus_own, 1);
`ifdef FETCH_STATS_EN
      check("stats_count", instr_count, 16'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
